// File: rtl/demux_pkg.sv
// Shared types and constants for the dual 1-of-4 addressable latch.
package demux_pkg;

    localparam int NPOS = 4;
    localparam logic [1:0] LAST_IDX = 2'(NPOS - 1);

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        WRITE = 2'b01,
        CLEAR = 2'b10,
        SEQ   = 2'b11
    } mode_t;

endpackage

// File: rtl/alatch4.sv
// One 4-position addressable lane: index 0 is the MSB of q. Clear wins over write.
module alatch4
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        idx,
    input  logic              d,
    input  logic              we,
    input  logic              clr,
    output logic [0:NPOS-1]   q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (we) begin
            q[idx] <= d;
        end
    end

endmodule

// File: rtl/demux2x4_latch.sv
// Dual 1-of-4 addressable latch with sequential-load pointer and wrap pulse.
// Optional readback outputs RB0/RB1 are built when DEMUX2X4_READBACK_EN is defined.
module demux2x4_latch
    import demux_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [0:1]  MODE,
    input  logic [0:1]  SEL,
    input  logic        START,
    input  logic        B0,
    input  logic        B1,
    output logic [0:3]  Q0,
    output logic [0:3]  Q1,
    output logic [0:1]  PTR,
    output logic        DONE
`ifdef DEMUX2X4_READBACK_EN
    ,
    output logic        RB0,
    output logic        RB1
`endif
);

    mode_t       mode;
    logic [1:0]  seq_idx;
    logic [1:0]  wr_idx;
    logic        wr_en;
    logic        clr_en;

    assign mode    = mode_t'(MODE);
    // START overrides the pointer for the write issued in the same cycle.
    assign seq_idx = START ? 2'd0 : PTR;
    assign wr_idx  = (mode == SEQ) ? seq_idx : SEL;
    assign wr_en   = EN && ((mode == WRITE) || (mode == SEQ));
    assign clr_en  = EN && (mode == CLEAR);

    alatch4 u_lane0 (
        .clk (CLK),
        .rst (RESET),
        .idx (wr_idx),
        .d   (B0),
        .we  (wr_en),
        .clr (clr_en),
        .q   (Q0)
    );

    alatch4 u_lane1 (
        .clk (CLK),
        .rst (RESET),
        .idx (wr_idx),
        .d   (B1),
        .we  (wr_en),
        .clr (clr_en),
        .q   (Q1)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PTR  <= 2'd0;
            DONE <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (EN) begin
                if (mode == SEQ) begin
                    PTR  <= seq_idx + 2'd1;
                    DONE <= (seq_idx == LAST_IDX);
                end else if ((mode == CLEAR) || START) begin
                    PTR <= 2'd0;
                end
            end
        end
    end

`ifdef DEMUX2X4_READBACK_EN
    // Samples pre-edge register contents, so a same-index write reads old data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RB0 <= 1'b0;
            RB1 <= 1'b0;
        end else begin
            RB0 <= Q0[SEL];
            RB1 <= Q1[SEL];
        end
    end
`endif

endmodule

// File: tb/tb_demux2x4_latch.sv
// Directed self-checking bench for demux2x4_latch (readback checks when DEMUX2X4_READBACK_EN is defined).
module tb_demux2x4_latch;

    logic        CLK;
    logic        RESET;
    logic        EN;
    logic [0:1]  MODE;
    logic [0:1]  SEL;
    logic        START;
    logic        B0;
    logic        B1;
    logic [0:3]  Q0;
    logic [0:3]  Q1;
    logic [0:1]  PTR;
    logic        DONE;
`ifdef DEMUX2X4_READBACK_EN
    logic        RB0;
    logic        RB1;
`endif

    int checks = 0;
    int errors = 0;

    demux2x4_latch dut (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .MODE  (MODE),
        .SEL   (SEL),
        .START (START),
        .B0    (B0),
        .B1    (B1),
        .Q0    (Q0),
        .Q1    (Q1),
        .PTR   (PTR),
        .DONE  (DONE)
`ifdef DEMUX2X4_READBACK_EN
        ,
        .RB0   (RB0),
        .RB1   (RB1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_all();
        EN = 1'b1; MODE = 2'b10; START = 1'b0;
        step();
        MODE = 2'b00;
    endtask

    task automatic test_reset();
        // build Q0=1010, PTR=2 first
        clear_all();
        MODE = 2'b01; SEL = 2'd2; B0 = 1'b1; B1 = 1'b1;
        step();
        MODE = 2'b11; START = 1'b1; B0 = 1'b1; B1 = 1'b0;
        step();
        START = 1'b0; B0 = 1'b0; B1 = 1'b1;
        step();
        checks++;
        if (Q0 !== 4'b1010 || PTR !== 2'd2) begin
            errors++;
            $display("FAIL reset_setup got Q0=%b PTR=%0d exp Q0=1010 PTR=2", Q0, PTR);
        end
        #1 RESET = 1'b1;
        #1;
        checks++;
        if (Q0 !== 4'b0000 || Q1 !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_q got Q0=%b Q1=%b exp 0000 0000", Q0, Q1);
        end
        checks++;
        if (PTR !== 2'd0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_ptr got PTR=%0d DONE=%b exp 0 0", PTR, DONE);
        end
        RESET = 1'b0;
        MODE = 2'b00;
    endtask

    task automatic test_addr_write();
        EN = 1'b1; MODE = 2'b01; SEL = 2'b10; B0 = 1'b1; B1 = 1'b0; START = 1'b0;
        step();
        checks++;
        if (Q0 !== 4'b0010 || Q1 !== 4'b0000) begin
            errors++;
            $display("FAIL addr_write got Q0=%b Q1=%b exp 0010 0000", Q0, Q1);
        end
        checks++;
        if (PTR !== 2'd0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL addr_ptr got PTR=%0d DONE=%b exp 0 0", PTR, DONE);
        end
        SEL = 2'b00; B0 = 1'b0; B1 = 1'b1;
        step();
        checks++;
        if (Q0 !== 4'b0010 || Q1 !== 4'b1000) begin
            errors++;
            $display("FAIL addr_write2 got Q0=%b Q1=%b exp 0010 1000", Q0, Q1);
        end
        MODE = 2'b00;
    endtask

    task automatic test_seq_load();
        clear_all();
        MODE = 2'b11; START = 1'b1; B0 = 1'b1; B1 = 1'b0;
        step();
        checks++;
        if (Q0 !== 4'b1000 || PTR !== 2'd1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL seq_first got Q0=%b PTR=%0d DONE=%b exp 1000 1 0", Q0, PTR, DONE);
        end
        START = 1'b0; B0 = 1'b0; B1 = 1'b1;
        step();
        B0 = 1'b1; B1 = 1'b1;
        step();
        checks++;
        if (DONE !== 1'b0 || PTR !== 2'd3) begin
            errors++;
            $display("FAIL seq_third got PTR=%0d DONE=%b exp 3 0", PTR, DONE);
        end
        B0 = 1'b1; B1 = 1'b0;
        step();
        checks++;
        if (Q0 !== 4'b1011 || Q1 !== 4'b0110) begin
            errors++;
            $display("FAIL seq_data got Q0=%b Q1=%b exp 1011 0110", Q0, Q1);
        end
        checks++;
        if (DONE !== 1'b1 || PTR !== 2'd0) begin
            errors++;
            $display("FAIL seq_done got PTR=%0d DONE=%b exp 0 1", PTR, DONE);
        end
        MODE = 2'b00;
        step();
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL seq_done_pulse got DONE=%b exp 0", DONE);
        end
    endtask

    task automatic test_pause_resume();
        int done_cnt;
        done_cnt = 0;
        clear_all();
        MODE = 2'b11; START = 1'b1; B0 = 1'b1; B1 = 1'b1;
        step();
        if (DONE === 1'b1) done_cnt++;
        START = 1'b0; B0 = 1'b0; B1 = 1'b1;
        step();
        if (DONE === 1'b1) done_cnt++;
        EN = 1'b0; B0 = 1'b1; B1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (DONE === 1'b1) done_cnt++;
            checks++;
            if (PTR !== 2'd2 || Q0 !== 4'b1000 || Q1 !== 4'b1100) begin
                errors++;
                $display("FAIL pause_hold[%0d] got PTR=%0d Q0=%b Q1=%b exp 2 1000 1100", i, PTR, Q0, Q1);
            end
        end
        EN = 1'b1; B0 = 1'b1; B1 = 1'b0;
        step();
        if (DONE === 1'b1) done_cnt++;
        B0 = 1'b1; B1 = 1'b1;
        step();
        if (DONE === 1'b1) done_cnt++;
        checks++;
        if (Q0 !== 4'b1011 || Q1 !== 4'b1101) begin
            errors++;
            $display("FAIL resume_data got Q0=%b Q1=%b exp 1011 1101", Q0, Q1);
        end
        MODE = 2'b00;
        step();
        if (DONE === 1'b1) done_cnt++;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL resume_done_count got %0d exp 1", done_cnt);
        end
    endtask

    task automatic test_clear_start();
        clear_all();
        MODE = 2'b11; START = 1'b1; B0 = 1'b1; B1 = 1'b0;
        step();
        START = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (Q0 !== 4'b1111 || PTR !== 2'd1) begin
            errors++;
            $display("FAIL clr_setup got Q0=%b PTR=%0d exp 1111 1", Q0, PTR);
        end
        MODE = 2'b10;
        step();
        checks++;
        if (Q0 !== 4'b0000 || Q1 !== 4'b0000 || PTR !== 2'd0) begin
            errors++;
            $display("FAIL clear got Q0=%b Q1=%b PTR=%0d exp 0000 0000 0", Q0, Q1, PTR);
        end
        MODE = 2'b11; B0 = 1'b0; B1 = 1'b0;
        for (int i = 0; i < 3; i++) step();
        START = 1'b1; B0 = 1'b1; B1 = 1'b1;
        step();
        checks++;
        if (Q0 !== 4'b1000 || Q1 !== 4'b1000 || PTR !== 2'd1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL start_prio got Q0=%b Q1=%b PTR=%0d DONE=%b exp 1000 1000 1 0", Q0, Q1, PTR, DONE);
        end
        MODE = 2'b01; SEL = 2'd3; B0 = 1'b1; B1 = 1'b0;
        step();
        checks++;
        if (Q0 !== 4'b1001 || PTR !== 2'd0) begin
            errors++;
            $display("FAIL start_write got Q0=%b PTR=%0d exp 1001 0", Q0, PTR);
        end
        START = 1'b0; MODE = 2'b11; B0 = 1'b0;
        step();
        EN = 1'b0; START = 1'b1;
        step();
        checks++;
        if (PTR !== 2'd1 || Q0 !== 4'b0001) begin
            errors++;
            $display("FAIL start_no_en got PTR=%0d Q0=%b exp 1 0001", PTR, Q0);
        end
        EN = 1'b1; START = 1'b0; MODE = 2'b00;
    endtask

`ifdef DEMUX2X4_READBACK_EN
    task automatic test_readback();
        clear_all();
        MODE = 2'b01; SEL = 2'b01; B0 = 1'b1; B1 = 1'b0;
        step();
        B0 = 1'b0;
        step();
        checks++;
        if (RB0 !== 1'b1 || RB1 !== 1'b0 || Q0 !== 4'b0000) begin
            errors++;
            $display("FAIL readback_old got RB0=%b RB1=%b Q0=%b exp 1 0 0000", RB0, RB1, Q0);
        end
        MODE = 2'b00;
        step();
        checks++;
        if (RB0 !== 1'b0) begin
            errors++;
            $display("FAIL readback_new got RB0=%b exp 0", RB0);
        end
    endtask
`endif

    initial begin
        RESET = 1'b1; EN = 1'b0; MODE = 2'b00; SEL = 2'b00;
        START = 1'b0; B0 = 1'b0; B1 = 1'b0;
        #12;
        checks++;
        if (Q0 !== 4'b0000 || Q1 !== 4'b0000 || PTR !== 2'd0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got Q0=%b Q1=%b PTR=%0d DONE=%b exp 0000 0000 0 0", Q0, Q1, PTR, DONE);
        end
        RESET = 1'b0;
        test_reset();
        test_addr_write();
        test_seq_load();
        test_pause_resume();
        test_clear_start();
`ifdef DEMUX2X4_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux2x4_latch.md
# demux2x4_latch

Dual 1-of-4 addressable latch: the write-side counterpart of the dual 1-of-4 mux. Each clock it steers two serial data bits (B0, B1) into one selected position of two 4-bit registers (Q0, Q1), or clears them, or loads them sequentially under an internal auto-incrementing pointer. It sits in front of mux2x4 wherever a 4-position field is built bit-serially and read back by select.

## Interface
Parameters:
- None. Width is fixed at 2 lanes × 4 positions.

Ports:
- CLK  input  1  sole clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- EN  input  1  operation enable; when 0, no state changes (except RESET).
- MODE  input  [0:1]  00 hold, 01 addressed write, 10 clear all, 11 sequential load.
- SEL  input  [0:1]  bit index for addressed write (and readback); 00 selects index 0 (MSB).
- START  input  1  forces the sequential pointer to 0; only qualified by EN.
- B0  input  1  data bit for lane 0.
- B1  input  1  data bit for lane 1.
- Q0  output  [0:3]  lane-0 register.
- Q1  output  [0:3]  lane-1 register.
- PTR  output  [0:1]  current sequential-load pointer.
- DONE  output  1  one-cycle pulse after the sequential write to index 3.

## Operation
- RESET asserted: Q0=Q1=4'b0000, PTR=0, DONE=0, RB0=RB1=0 (if built), all immediately and held until deassertion.
- EN=0: Q0, Q1 and PTR hold. DONE drops to 0.
- EN=1, MODE=00: hold; DONE=0.
- EN=1, MODE=01: Q0[SEL]<=B0, Q1[SEL]<=B1; other bits hold. PTR unchanged.
- EN=1, MODE=10: Q0, Q1 <= 0; PTR <= 0.
- EN=1, MODE=11: write index p = (START ? 0 : PTR); Q0[p]<=B0, Q1[p]<=B1; PTR <= p+1 mod 4; DONE <= (p==3).
- START with MODE≠11 and EN=1: PTR<=0; the MODE action otherwise proceeds unchanged. START with EN=0 is ignored.
- Pointer wrap: 3→0 sets DONE for exactly one cycle. A sequence continues seamlessly into the next pass if EN/MODE stay asserted, and DONE pulses once per pass.
- Leaving MODE 11 mid-sequence freezes PTR; resuming MODE 11 continues from the frozen index.
- DONE is 0 in every cycle not following a sequential write to index 3.

## Timing
- All writes are visible on Q0/Q1 the cycle after the qualifying edge (latency 1).
- PTR and DONE update on the same edge as the associated write.
- No combinational path from any input to any output.
- RESET deassertion: first active edge operates normally; deassert synchronously to CLK externally.

## Configuration
- DEMUX2X4_READBACK_EN defined: adds outputs RB0 and RB1 (1 bit each). On every edge, RB0<=Q0[SEL] and RB1<=Q1[SEL], using pre-edge Q values (read-before-write when the same index is written). Reset value 0. Independent of EN.
- Not defined: RB0/RB1 ports do not exist; no readback logic.

## Structure
- Shared package demux_pkg: enum type for MODE (HOLD, WRITE, CLEAR, SEQ) and constant NPOS=4.
- One sub-module, alatch4: a single 4-bit addressable lane (index, data, write strobe, clear). Instantiated twice; pointer, START handling and DONE live in the top level.

## Test plan
- Reset: assert RESET mid-sequence with Q0=1010, PTR=2 → Q0=Q1=0000, PTR=0, DONE=0 without a clock edge.
- Addressed write: EN=1, MODE=01, SEL=10, B0=1, B1=0 from zero → Q0=0010, Q1=0000 next cycle; PTR unchanged.
- Sequential load: START+MODE=11, B0 stream 1,0,1,1, B1 stream 0,1,1,0 → Q0=1011, Q1=0110; DONE high exactly in the cycle after the 4th write; PTR=0.
- Pause/resume: MODE=11 for two writes, EN=0 for three cycles, then two more writes → PTR held at 2 during pause; final registers as if uninterrupted; one DONE pulse.
- Clear and START priority: MODE=10 with Q0=1111 → 0000, PTR=0; START during MODE=11 with PTR=3 → write goes to index 0, PTR=1, no DONE.
- Readback (macro defined): Q0=0100, SEL=01, MODE=01 writing B0=0 → RB0=1 that edge, then RB0=0 on the following edge.
